// File: rtl/exe_mem_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : exe_mem_skid_reg
// Description : EXE->MEM pipeline register with a one-entry skid buffer.
//               Holds up to two entries (main = head, skid = overflow) so
//               that in_ready comes straight from a register and never
//               combinationally from out_ready. The head entry is presented
//               on the outputs one cycle after acceptance. Payload and
//               control outputs read as zero whenever no entry is presented,
//               so a bubble can never write memory or the register file.
//
// Ports       : clk, rst                    clock, synchronous active-high reset
//               flush                       synchronous kill of all held entries
//               in_valid / in_ready         upstream handshake
//               pc_in, alu_res_in,
//               val_rm_in, dest_in, ctrl_in upstream payload
//               out_valid / out_ready       downstream handshake
//               pc_out, alu_res_out,
//               val_rm_out, dest_out,
//               ctrl_out                    head payload (zero when empty)
//               occupancy                   number of held entries, 0..2
//
// Revision    : 1.0 - initial release
// ============================================================================
module exe_mem_skid_reg #(
    parameter int ADDR_W = 32,
    parameter int DEST_W = 4,
    parameter int CTRL_W = 3   // {MEM_W_EN, MEM_R_EN, WB_EN}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [ADDR_W-1:0] alu_res_in,
    input  logic [ADDR_W-1:0] val_rm_in,
    input  logic [DEST_W-1:0] dest_in,
    input  logic [CTRL_W-1:0] ctrl_in,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] alu_res_out,
    output logic [ADDR_W-1:0] val_rm_out,
    output logic [DEST_W-1:0] dest_out,
    output logic [CTRL_W-1:0] ctrl_out,

    output logic [1:0]        occupancy
);

    // One entry packed as {pc, alu_res, val_rm, dest, ctrl}.
    localparam int ENT_W = 3*ADDR_W + DEST_W + CTRL_W;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [ENT_W-1:0]   main_q,  main_d;
    logic [ENT_W-1:0]   skid_q,  skid_d;

    logic [ENT_W-1:0]   w_in_entry;
    logic               w_accept;
    logic               w_pop;

    assign w_in_entry = {pc_in, alu_res_in, val_rm_in, dest_in, ctrl_in};

    // Handshake outputs depend only on the state register.
    assign in_ready  = (state_q != S_TWO);
    assign out_valid = (state_q != S_EMPTY);
    assign occupancy = state_q;

    assign w_accept  = in_valid  & in_ready;
    assign w_pop     = out_valid & out_ready;

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush) begin
            // Flush outranks every handshake in the same cycle.
            state_d = S_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            unique case (state_q)
                S_EMPTY: begin
                    if (w_accept) begin
                        main_d  = w_in_entry;
                        state_d = S_ONE;
                    end
                end

                S_ONE: begin
                    if (w_accept && w_pop) begin
                        // Head leaves and the new entry takes its place.
                        main_d  = w_in_entry;
                    end else if (w_accept) begin
                        // Downstream stalled: park the new entry in skid.
                        skid_d  = w_in_entry;
                        state_d = S_TWO;
                    end else if (w_pop) begin
                        main_d  = '0;
                        state_d = S_EMPTY;
                    end
                end

                S_TWO: begin
                    // in_ready is low here, so only a pop can happen.
                    if (w_pop) begin
                        main_d  = skid_q;
                        skid_d  = '0;
                        state_d = S_ONE;
                    end
                end

                default: begin
                    state_d = S_EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // ------------------------------------------------------------------
    // Head outputs, gated so an empty register presents all zeros.
    // ------------------------------------------------------------------
    logic [ENT_W-1:0] w_head;

    assign w_head = out_valid ? main_q : '0;

    assign {pc_out, alu_res_out, val_rm_out, dest_out, ctrl_out} = w_head;

endmodule
`default_nettype wire

// File: tb/tb_exe_mem_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_exe_mem_skid_reg
// Description : Self-checking bench for exe_mem_skid_reg. A FIFO queue of
//               depth two serves as the reference; directed scenarios are
//               followed by a long randomized handshake run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exe_mem_skid_reg;

    localparam int AW = 32;
    localparam int DW = 4;
    localparam int CW = 3;

    typedef struct {
        logic [AW-1:0] pc;
        logic [AW-1:0] alu;
        logic [AW-1:0] rm;
        logic [DW-1:0] dest;
        logic [CW-1:0] ctrl;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [AW-1:0] pc_in, alu_res_in, val_rm_in, pc_out, alu_res_out, val_rm_out;
    logic [DW-1:0] dest_in, dest_out;
    logic [CW-1:0] ctrl_in, ctrl_out;
    logic [1:0]    occupancy;

    always #5 clk = ~clk;

    exe_mem_skid_reg #(.ADDR_W(AW), .DEST_W(DW), .CTRL_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .pc_in       (pc_in),
        .alu_res_in  (alu_res_in),
        .val_rm_in   (val_rm_in),
        .dest_in     (dest_in),
        .ctrl_in     (ctrl_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .pc_out      (pc_out),
        .alu_res_out (alu_res_out),
        .val_rm_out  (val_rm_out),
        .dest_out    (dest_out),
        .ctrl_out    (ctrl_out),
        .occupancy   (occupancy)
    );

    // Reference: an ordered list of held entries, at most two long.
    ent_t q[$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_in(input logic iv, input ent_t e);
        in_valid   = iv;
        pc_in      = e.pc;
        alu_res_in = e.alu;
        val_rm_in  = e.rm;
        dest_in    = e.dest;
        ctrl_in    = e.ctrl;
    endtask

    function automatic ent_t mk(input logic [AW-1:0] pc, input logic [AW-1:0] alu,
                                input logic [DW-1:0] dest, input logic [CW-1:0] ctrl);
        ent_t e;
        e.pc = pc; e.alu = alu; e.rm = alu ^ 32'h5A5A_0000; e.dest = dest; e.ctrl = ctrl;
        return e;
    endfunction

    function automatic ent_t rnd_ent();
        ent_t e;
        e.pc = $urandom; e.alu = $urandom; e.rm = $urandom;
        e.dest = DW'($urandom); e.ctrl = CW'($urandom);
        return e;
    endfunction

    // Compare every output against the reference queue.
    task automatic compare_all(input string tag);
        int   n;
        ent_t h;
        n = q.size();
        check({tag, "_occ"},   64'(occupancy), 64'(n));
        check({tag, "_oval"},  64'(out_valid), 64'(n != 0));
        check({tag, "_irdy"},  64'(in_ready),  64'(n < 2));
        if (n != 0) h = q[0];
        else h = mk('0, '0, '0, '0);
        if (n == 0) h.rm = '0;
        check({tag, "_pc"},   64'(pc_out),      64'(h.pc));
        check({tag, "_alu"},  64'(alu_res_out), 64'(h.alu));
        check({tag, "_rm"},   64'(val_rm_out),  64'(h.rm));
        check({tag, "_dest"}, 64'(dest_out),    64'(h.dest));
        check({tag, "_ctrl"}, 64'(ctrl_out),    64'(h.ctrl));
    endtask

    // One clock: advance the reference with the inputs seen at the edge,
    // then sample the DUT shortly after the edge.
    task automatic step(input string tag);
        bit   acc, pp;
        ent_t e;
        @(posedge clk);
        acc = in_valid && (q.size() < 2);
        pp  = out_ready && (q.size() > 0);
        e.pc = pc_in; e.alu = alu_res_in; e.rm = val_rm_in; e.dest = dest_in; e.ctrl = ctrl_in;
        if (rst || flush) begin
            q.delete();
        end else begin
            if (pp)  void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        #1;
        compare_all(tag);
    endtask

    ent_t idle;
    ent_t ea, eb;

    initial begin
        idle = mk('0, '0, '0, '0);
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        set_in(1'b0, idle);
        step("rst0");
        step("rst1");
        rst = 1'b0;

        // Pass-through
        out_ready = 1'b1;
        set_in(1'b1, mk(32'h100, 32'h5, 4'd3, 3'b001));
        step("pt");
        check("pt_alu_const",  64'(alu_res_out), 64'h5);
        check("pt_ctrl_const", 64'(ctrl_out),    64'h1);
        check("pt_occ_const",  64'(occupancy),   64'd1);
        set_in(1'b0, idle);
        step("pt_drain");

        // Skid fill
        out_ready = 1'b0;
        ea = mk(32'h200, 32'hA, 4'd1, 3'b100);
        eb = mk(32'h204, 32'hB, 4'd2, 3'b011);
        set_in(1'b1, ea); step("fillA");
        set_in(1'b1, eb); step("fillB");
        check("fill_occ2", 64'(occupancy),   64'd2);
        check("fill_irdy", 64'(in_ready),    64'd0);
        check("fill_head", 64'(alu_res_out), 64'hA);
        set_in(1'b1, mk(32'h208, 32'hC, 4'd4, 3'b111));
        step("fill_third");
        check("third_head", 64'(alu_res_out), 64'hA);

        // Drain order
        set_in(1'b0, idle);
        out_ready = 1'b1;
        step("drain1");
        check("drain1_head", 64'(alu_res_out), 64'hB);
        step("drain2");
        check("drain2_oval", 64'(out_valid), 64'd0);
        check("drain2_ctrl", 64'(ctrl_out),  64'd0);

        // Flush while full, with both handshakes active
        out_ready = 1'b0;
        set_in(1'b1, ea); step("ffA");
        set_in(1'b1, eb); step("ffB");
        flush = 1'b1; out_ready = 1'b1;
        set_in(1'b1, mk(32'h300, 32'hD, 4'd5, 3'b010));
        step("flush");
        check("flush_occ",  64'(occupancy), 64'd0);
        check("flush_irdy", 64'(in_ready),  64'd1);
        flush = 1'b0;
        set_in(1'b0, idle);
        step("post_flush");
        check("post_flush_oval", 64'(out_valid), 64'd0);

        // Reset while full
        out_ready = 1'b0;
        set_in(1'b1, ea); step("rfA");
        set_in(1'b1, eb); step("rfB");
        rst = 1'b1; flush = 1'b1; out_ready = 1'b1;
        step("rst_two");
        check("rst_two_irdy", 64'(in_ready), 64'd1);
        rst = 1'b0; flush = 1'b0;
        set_in(1'b1, mk(32'h400, 32'hE, 4'd6, 3'b001));
        step("after_rst");
        check("after_rst_alu", 64'(alu_res_out), 64'hE);
        set_in(1'b0, idle);
        step("after_rst_drain");

        // Randomized handshakes, bias changing every 1000 cycles
        for (int i = 0; i < 10000; i++) begin
            int pv, pr;
            pv = 20 + 15 * ((i / 1000) % 5);
            pr = 80 - 15 * ((i / 1000) % 5);
            set_in(($urandom % 100) < pv, rnd_ent());
            out_ready = ($urandom % 100) < pr;
            flush     = ($urandom % 97) == 0;
            rst       = ($urandom % 499) == 0;
            step("rnd");
            check("rnd_occ_le2", 64'(occupancy <= 2), 64'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
